rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares one BITS-wide datapath among WORDS requesters.
//  It computes the winning index, drives the shared Mux select with it, and registers the selected beat into a single output stage.
//  Requesters and the consumer use valid/ready handshakes.
//  Sits in front of any shared resource port (e.g. a writeback or memory request port).
// PARAMETERS
//  BITS   64  width of each request payload and of out_data
//  WORDS  2   number of requesters; legal range 2..16
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   WORDS       per-requester valid
//  req_data   in   WORDS*BITS  packed payloads; requester i at [i*BITS +: BITS]
//  req_ready  out  WORDS       one-hot; beat i is accepted when req_valid[i] && req_ready[i]
//  out_valid  out  1           output register holds a beat
//  out_data   out  BITS        registered payload
//  out_src    out  $clog2(WORDS)  index of the requester that supplied out_data
//  out_ready  in   1           consumer accepts the beat when out_valid && out_ready
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_src=0, req_ready=0, priority pointer ptr=0.
//  - Reset asserted mid-operation discards any held beat. No handshake completes in a reset cycle.
//  - Load enable: load = !out_valid || out_ready.
//  - Flow-through: a beat leaving and a new beat loading in the same cycle is legal. Throughput is 1 beat/cycle.
//  - Pick: the first i with req_valid[i] set, scanning ptr, ptr+1, ... mod WORDS.
//  - req_ready[pick] = load && any_valid; every other req_ready bit is 0.
//  - req_ready is combinational from req_valid, ptr and out_ready.
//  - On acceptance:
//      - out_data <= req_data[pick]; out_src <= pick; out_valid <= 1.
//      - ptr <= (pick+1) mod WORDS. Wrap: pick=WORDS-1 -> ptr=0.
//  - No acceptance while out_ready=1: out_valid <= 0, and ptr is unchanged.
//  - Stall (out_valid && !out_ready):
//      - out_data, out_src and out_valid hold stable.
//      - All req_ready bits are 0. ptr holds.
//  - Latency: accepted in cycle N -> visible on out_* in cycle N+1.
//  - Fairness: with all WORDS requesters continuously valid, each is granted once per WORDS accepted beats.
//  - No requests: out_valid falls after the held beat drains. No spurious beats.
//  - ptr advances only on an accepted beat, never on an idle cycle.
// CONFIGURATION
//  RR_ARB_LOCK_EN: packet lock.
//  - Defined:
//      - Adds input req_last [WORDS] (last beat of a packet).
//      - Two-state FSM: UNLOCKED -> LOCKED when a beat with req_last[pick]=0 is accepted. lock_src <= pick.
//      - In LOCKED only lock_src is eligible. Other requesters see req_ready=0 even if lock_src is idle.
//      - LOCKED -> UNLOCKED when a lock_src beat with req_last=1 is accepted. Only then does ptr <= lock_src+1.
//      - Reset -> UNLOCKED.
//  - Undefined: no req_last port; every beat is arbitrated independently, as described above.
// STRUCTURE
//  - Shared package arb_pkg:
//      - localparam function src_w(WORDS) = $clog2(WORDS).
//      - typedef arb_state_e {ARB_UNLOCKED, ARB_LOCKED}, used only under RR_ARB_LOCK_EN.
//  - Sub-module rr_pick (combinational): inputs valid[WORDS] and ptr; outputs any and idx. Implemented as a rotate, fixed-priority encode, un-rotate.
//  - Payload selection instantiates the existing Mux (BITS, WORDS) with sel=idx; the packed req_data is unpacked to Mux's array input.
// TESTING
//  1 Reset with req_valid=all 1 -> out_valid=0, req_ready=0. First cycle after reset grants requester 0, and it appears on out_* one cycle later.
//  2 WORDS=4, all valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; one beat per cycle.
//  3 out_ready=0 for 3 cycles while out_valid=1 (data=0xA5) -> out_data=0xA5 stable; req_ready=0; ptr unchanged afterwards.
//  4 Only requester 3 valid with ptr=1 -> grant 3, ptr wraps to 0. Requester 0 is then granted before 1 when both are valid.
//  5 Reset pulsed with out_valid=1, out_ready=0 -> next cycle out_valid=0 and ptr=0; the held beat never completes.
//  6 RR_ARB_LOCK_EN: req 0 sends 3 beats (last on the third) while req 1 is valid throughout -> out_src 0,0,0,1.
//    Without the macro the same stimulus gives 0,1,0,1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter slice.
package arb_pkg;

  function automatic int src_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux.sv
// Generic WORDS-to-1 payload multiplexer; out-of-range selects yield zero.
module Mux
  import arb_pkg::*;
#(
  parameter int BITS  = 64,
  parameter int WORDS = 2
) (
  input  logic [BITS-1:0]          data [WORDS],
  input  logic [src_w(WORDS)-1:0]  sel,
  output logic [BITS-1:0]          result
);

  localparam int SW = src_w(WORDS);

  always_comb begin
    result = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (sel == SW'(i)) result = data[i];
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: rotate valid by ptr, fixed-priority encode, un-rotate. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic [WORDS-1:0]         valid,
  input  logic [src_w(WORDS)-1:0]  ptr,
  output logic                     any,
  output logic [src_w(WORDS)-1:0]  idx
);

  localparam int SW = src_w(WORDS);

  logic [WORDS-1:0] rotated;
  logic [SW-1:0]    src;
  int               first;
  int               sum;

  always_comb begin
    rotated = '0;
    src     = '0;
    first   = 0;
    sum     = 0;
    for (int j = 0; j < WORDS; j++) begin
      src        = SW'((int'(ptr) + j) % WORDS);
      rotated[j] = valid[src];
    end
    // Descending scan leaves the lowest set rotated position in 'first'.
    for (int j = WORDS - 1; j >= 0; j--) begin
      if (rotated[j]) first = j;
    end
    any = |rotated;
    sum = int'(ptr) + first;
    if (sum >= WORDS) sum = sum - WORDS;
    idx = SW'(sum);
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter + shared mux into one output register; 1-cycle latency, 1 beat/cycle with flow-through.
// Stalls hold the output and drop all req_ready; RR_ARB_LOCK_EN adds req_last packet locking.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int BITS  = 64,
  parameter int WORDS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef RR_ARB_LOCK_EN
  input  logic [WORDS-1:0]          req_last,
`endif
  input  logic [WORDS-1:0]          req_valid,
  input  logic [WORDS*BITS-1:0]     req_data,
  output logic [WORDS-1:0]          req_ready,
  output logic                      out_valid,
  output logic [BITS-1:0]           out_data,
  output logic [src_w(WORDS)-1:0]   out_src,
  input  logic                      out_ready
);

  localparam int SW = src_w(WORDS);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    idx;
  logic [SW-1:0]    ptr_next;
  logic [WORDS-1:0] eligible;
  logic             any;
  logic             load;
  logic             accept;
  logic             advance;
  logic [BITS-1:0]  words [WORDS];
  logic [BITS-1:0]  sel_data;

  always_comb begin
    for (int i = 0; i < WORDS; i++) words[i] = req_data[i*BITS +: BITS];
  end

  rr_pick #(.WORDS(WORDS)) pick (
    .valid (eligible),
    .ptr   (ptr),
    .any   (any),
    .idx   (idx)
  );

  Mux #(.BITS(BITS), .WORDS(WORDS)) payload_mux (
    .data   (words),
    .sel    (idx),
    .result (sel_data)
  );

  assign load      = !out_valid || out_ready;
  assign accept    = load && any && !reset;
  assign req_ready = accept ? (WORDS'(1) << idx) : '0;
  assign ptr_next  = (idx == SW'(WORDS - 1)) ? '0 : idx + 1'b1;

`ifdef RR_ARB_LOCK_EN
  arb_state_e state;
  arb_state_e state_next;
  logic [SW-1:0] lock_src;

  // While locked, only the packet owner may win, even when it is idle.
  always_comb begin
    eligible = req_valid;
    if (state == ARB_LOCKED) eligible = req_valid & (WORDS'(1) << lock_src);
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      ARB_UNLOCKED: begin
        if (accept) begin
          if (req_last[idx]) advance    = 1'b1;
          else               state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept && req_last[idx]) begin
          advance    = 1'b1;
          state_next = ARB_UNLOCKED;
        end
      end
      default: state_next = ARB_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_UNLOCKED;
      lock_src <= '0;
    end else begin
      state <= state_next;
      if (state == ARB_UNLOCKED && accept && !req_last[idx]) lock_src <= idx;
    end
  end
`else
  assign eligible = req_valid;
  assign advance  = accept;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (advance) ptr <= ptr_next;
    end
  end

endmodule
